// File: rtl/uart_pkg.sv
// Shared constants for the UART byte transmitter.
// State encodings, idle line level and default baud divider.
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_START  = 3'd1;
   localparam state_t S_DATA   = 3'd2;
   localparam state_t S_PARITY = 3'd3;
   localparam state_t S_STOP   = 3'd4;

   localparam int   DEFAULT_CLKS_PER_BIT = 5208;
   localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_byte_tx_baud.sv
// Baud divider: counts 0..CLKS_PER_BIT-1, ticks on the wrap cycle.
// A synchronous clear restarts the count on every state entry.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 4,
   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == W'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start, 8 data bits LSB first, optional even
// parity, 1 or 2 stop bits. Launches on a rising edge of out_start.
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter bit PARITY_EN    = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] out_data,
   input  logic       out_start,
   output logic       out_finish,
   output logic       tx,
   output logic       tx_overrun
);

   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] idx_q, idx_d;
   logic       parity_q, parity_d;
   logic       start_q, start_d;
   logic       tx_q, tx_d;
   logic       fin_q, fin_d;
   logic       ovr_q, ovr_d;
   logic       tick;
   logic       clr;
   logic       rise;

   assign rise = out_start & ~start_q;

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      parity_d = parity_q;
      tx_d     = tx_q;
      fin_d    = fin_q;
      start_d  = out_start;
      ovr_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            tx_d  = IDLE_LEVEL;
            fin_d = 1'b1;
            if (rise) begin
               shift_d  = out_data;
               parity_d = ^out_data;
               tx_d     = 1'b0;
               fin_d    = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (tick) begin
               if (idx_q == 3'd7) begin
                  idx_d = '0;
                  if (PARITY_EN) begin
                     state_d = S_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = IDLE_LEVEL;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[idx_q + 3'd1];
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               state_d = S_STOP;
               idx_d   = '0;
               tx_d    = IDLE_LEVEL;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (idx_q == LAST_STOP) begin
                  state_d = S_IDLE;
                  fin_d   = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = IDLE_LEVEL;
            fin_d   = 1'b1;
         end
      endcase
      // a rise while busy, including the STOP completion edge, is dropped
      if (rise && state_q != S_IDLE) ovr_d = 1'b1;
   end

   assign clr = (state_q == S_IDLE) || (state_d != state_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         parity_q <= 1'b0;
         start_q  <= 1'b0;
         tx_q     <= IDLE_LEVEL;
         fin_q    <= 1'b1;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         parity_q <= parity_d;
         start_q  <= start_d;
         tx_q     <= tx_d;
         fin_q    <= fin_d;
         ovr_q    <= ovr_d;
      end
   end

   assign tx         = tx_q;
   assign out_finish = fin_q;
   assign tx_overrun = ovr_q;

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serial transmit stage directly downstream of the FIFO drain stage.
- Accepts one byte per out_start handshake on out_data.
- Serialises each byte as a UART frame on tx: start bit, LSB-first data, optional even parity, stop bit(s).
- Reports idle/done to the upstream stage on out_finish, which gates the next FIFO read.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per serial bit (50 MHz / 9600 baud); legal range >= 2.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- out_data  in  8  byte to send; stable from before the out_start rise.
- out_start  in  1  launch request from upstream; level held until upstream sees out_finish.
- out_finish  out  1  1 = idle/last frame complete; 0 = frame in progress.
- tx  out  1  serial line, idle high.
- tx_overrun  out  1  one-cycle pulse when an out_start rise is dropped.

Behaviour:
- Reset (async assert, rst_n=0), effective immediately even mid-frame:
  - tx=1, out_finish=1, tx_overrun=0.
  - state=IDLE; baud counter, bit index and start_q all cleared.
  - No partial frame resumes after release.
- Launch rule:
  - Register start_q <= out_start every cycle.
  - Accept only on a rising edge (out_start=1 && start_q=0) while state=IDLE.
  - A level-held out_start never retriggers.
  - This is required: upstream drops out_start only after out_finish returns to 1.
- On the accepting edge E:
  - Latch out_data into shift_reg.
  - Compute parity = XOR of the 8 data bits.
  - out_finish<=0, tx<=0, state<=START.
  - Latency: tx low starting the first cycle after E.
- States:
  - IDLE: tx=1, out_finish=1.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit index 0.
  - DATA: tx=shift_reg[idx] for CLKS_PER_BIT cycles each; idx 0..7, LSB first. After idx 7 -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle's edge: out_finish<=1, state<=IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit advance occurs on wrap.
  - Width $clog2(CLKS_PER_BIT).
  - Counter resets to 0 on every state entry.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from E to out_finish=1.
- Busy collisions:
  - An out_start rise while state != IDLE is dropped and tx_overrun pulses for 1 cycle.
  - This includes a rise on the same edge that STOP completes; tx output is unaffected.
- out_data changes after E do not affect the frame in flight.
- Back-to-back frames:
  - The next rise is accepted any cycle after out_finish=1.
  - Minimum idle high between frames is 1 cycle plus upstream latency.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP; 3-bit encoding);
  - default CLKS_PER_BIT constant;
  - IDLE_LEVEL=1'b1.
- One natural sub-module: baud_tick_gen.
  - Parameterised counter with synchronous clear on state entry.
  - Emits a one-cycle tick on wrap.
- FSM, shift register and edge detect stay in uart_byte_tx.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset, then out_data=8'hA5, one-cycle out_start rise -> tx over 40 cycles reads 0,1,0,1,0,0,1,0,1,1 (4 cycles each); out_finish=0 for exactly those 40 cycles, then 1.
- PARITY_EN=1, out_data=8'h07 -> 11-bit frame ending parity=1, stop=1; out_finish low 44 cycles.
- out_start held high 100 cycles with 8'h3C -> exactly one frame sent; tx=1 after cycle 40; no overrun.
- Second out_start rise at cycle 10 of a frame -> tx_overrun=1 for one cycle; frame bits unchanged; no second frame.
- rst_n low at cycle 17 of a frame -> tx=1 and out_finish=1 immediately (before next clk edge); after release a new 8'h55 send produces a clean 40-cycle frame.
- Upstream model drains a 3-entry FIFO (8'h01, 8'h80, 8'hFF) using out_finish gating -> three frames in order, each preceded by idle high >= 1 cycle, no overrun.
